sm_muldiv: RTL

//  Iterative multiply/divide unit with HI/LO result registers for the schoolMIPS core.

---
 rtl/sm_muldiv_pkg.sv | 33 +++
 rtl/sm_muldiv_step.sv | 43 ++++
 rtl/sm_muldiv.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sm_muldiv_pkg.sv
// rtl/sm_muldiv_pkg.sv - shared op/funct codes and decode helpers for the mul/div unit
package sm_muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  // R-type funct field values used by the control decoder
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  function automatic logic md_is_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/sm_muldiv_step.sv
// rtl/sm_muldiv_step.sv - one combinational shift-add / restoring shift-subtract iteration
module sm_muldiv_step
  import sm_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
)(
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_mq,
  input  logic [WIDTH-1:0] i_operand,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_mq
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;

  always_comb begin
    w_sum     = '0;
    w_shifted = '0;
    w_diff    = '0;
    o_acc     = i_acc;
    o_mq      = i_mq;
    if (i_is_div) begin
      // a set top bit of the difference means the trial subtract borrowed
      w_shifted = {i_acc, i_mq[WIDTH-1]};
      w_diff    = w_shifted - {1'b0, i_operand};
      if (w_diff[WIDTH]) begin
        o_acc = w_shifted[WIDTH-1:0];
        o_mq  = {i_mq[WIDTH-2:0], 1'b0};
      end else begin
        o_acc = w_diff[WIDTH-1:0];
        o_mq  = {i_mq[WIDTH-2:0], 1'b1};
      end
    end else begin
      w_sum = i_mq[0] ? ({1'b0, i_acc} + {1'b0, i_operand}) : {1'b0, i_acc};
      o_acc = w_sum[WIDTH:1];
      o_mq  = {w_sum[0], i_mq[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/sm_muldiv.sv
// rtl/sm_muldiv.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
module sm_muldiv
  import sm_muldiv_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP} state_e;

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_mq;
  logic [WIDTH-1:0]   r_b;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div0;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic               w_sign_a;
  logic               w_sign_b;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_step_acc;
  logic [WIDTH-1:0]   w_step_mq;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_signed = md_is_signed(op);
  assign w_sign_a = w_signed & srcA[WIDTH-1];
  assign w_sign_b = w_signed & srcB[WIDTH-1];
  assign w_abs_a  = w_sign_a ? -srcA : srcA;
  assign w_abs_b  = w_sign_b ? -srcB : srcB;

  assign w_prod     = {r_acc, r_mq};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  // divide by zero leaves the raw all-ones quotient; the remainder fixup restores srcA
  assign w_quo_fix  = r_div0 ? {WIDTH{1'b1}} : (r_neg_q ? -r_mq : r_mq);
  assign w_rem_fix  = r_neg_r ? -r_acc : r_acc;

  sm_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div  (r_is_div),
    .i_acc     (r_acc),
    .i_mq      (r_mq),
    .i_operand (r_b),
    .o_acc     (w_step_acc),
    .o_mq      (w_step_mq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mq     <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !kill) begin
            if (op == MD_MTHI) begin
              r_hi <= srcA;
            end else if (op == MD_MTLO) begin
              r_lo <= srcA;
            end else if (md_is_arith(op)) begin
              r_is_div <= md_is_div(op);
              r_acc    <= '0;
              r_mq     <= w_abs_a;
              r_b      <= w_abs_b;
              r_neg_q  <= w_sign_a ^ w_sign_b;
              r_neg_r  <= w_sign_a;
              r_div0   <= md_is_div(op) && (srcB == '0);
              r_cnt    <= CNT_W'(WIDTH - 1);
              r_busy   <= 1'b1;
              r_state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (kill) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_step_acc;
            r_mq  <= w_step_mq;
            if (r_cnt == '0) begin
              r_state <= S_FIXUP;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
        S_FIXUP: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          if (!kill) begin
            r_done <= 1'b1;
            if (r_is_div) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end else begin
              r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              r_lo <= w_prod_fix[WIDTH-1:0];
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
